fetch_queue_unit: RTL and testbench

//  Parametrised instruction fetch stage. Owns the PC, issues reads to a synchronous
//  1-cycle-latency instruction memory, and buffers returned words with their PC in a

---
 rtl/fetch_queue_unit.sv | 70 +++++++
 tb/tb_fetch_queue_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the PC, issues 1-cycle imem reads and queues returned words for decode
module fetch_queue_unit #(
    parameter int ADDR_W = 7,
    parameter int INST_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk_n,
    input  logic                          rst_n,
    input  logic                          m_branch_en,
    input  logic [ADDR_W-1:0]             m_branch_addr,
    output logic                          imem_rd_en,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [INST_W-1:0]             imem_rdata,
    input  logic                          de_ready,
    output logic                          if_valid,
    output logic [INST_W-1:0]             if_curr_inst,
    output logic [ADDR_W-1:0]             if_pc,
    output logic [ADDR_W-1:0]             if_next_addr,
    output logic [$clog2(FIFO_DEPTH):0]   if_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);
    logic [ADDR_W-1:0] pc, inflight_pc;
    logic              inflight, pop, push, issue;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW+1:0]     credit;
    logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc [FIFO_DEPTH];
    assign pop = if_valid & de_ready;
    assign push = inflight & !m_branch_en;
    // queued + in flight - leaving this cycle; issuing only below depth keeps the FIFO from overflowing
    assign credit = {1'b0, if_count} + (PW+2)'(inflight) - (PW+2)'(pop);
    assign issue = !m_branch_en & (credit < DEPTH_C);
    assign imem_rd_en = issue;
    assign imem_addr = pc;
    assign if_valid = |if_count;
    assign if_curr_inst = fifo_inst[rd_ptr];
    assign if_pc = fifo_pc[rd_ptr];
    assign if_next_addr = if_pc + ADDR_W'(1);
    always_ff @(posedge clk_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            if_count <= '0;
        end else begin
            inflight <= issue;
            inflight_pc <= pc;
            pc <= m_branch_en ? m_branch_addr : issue ? pc + ADDR_W'(1) : pc;
            if (m_branch_en) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                if_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if_count <= if_count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk_n) begin
        if (rst_n && push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr] <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of fetch timing, back-pressure, redirects and reset
module tb_fetch_queue_unit;
    logic clk_n = 1'b0;
    always #5 clk_n = ~clk_n;
    int checks = 0;
    int errors = 0;
    logic        a_rst_n, a_br_en, a_rd_en, a_de_ready, a_valid;
    logic [6:0]  a_br_addr, a_addr, a_pc, a_next;
    logic [15:0] a_rdata, a_inst;
    logic [1:0]  a_count;
    logic        b_rst_n, b_br_en, b_rd_en, b_de_ready, b_valid;
    logic [9:0]  b_br_addr, b_addr, b_pc, b_next;
    logic [31:0] b_rdata, b_inst;
    logic [2:0]  b_count;
    fetch_queue_unit dut_a (
        .clk_n(clk_n), .rst_n(a_rst_n), .m_branch_en(a_br_en), .m_branch_addr(a_br_addr),
        .imem_rd_en(a_rd_en), .imem_addr(a_addr), .imem_rdata(a_rdata), .de_ready(a_de_ready),
        .if_valid(a_valid), .if_curr_inst(a_inst), .if_pc(a_pc), .if_next_addr(a_next),
        .if_count(a_count)
    );
    fetch_queue_unit #(.ADDR_W(10), .INST_W(32), .RESET_PC(10'h3FE), .FIFO_DEPTH(4)) dut_b (
        .clk_n(clk_n), .rst_n(b_rst_n), .m_branch_en(b_br_en), .m_branch_addr(b_br_addr),
        .imem_rd_en(b_rd_en), .imem_addr(b_addr), .imem_rdata(b_rdata), .de_ready(b_de_ready),
        .if_valid(b_valid), .if_curr_inst(b_inst), .if_pc(b_pc), .if_next_addr(b_next),
        .if_count(b_count)
    );
    always @(posedge clk_n) if (a_rd_en) a_rdata <= 16'h0100 + {9'd0, a_addr};
    always @(posedge clk_n) if (b_rd_en) b_rdata <= 32'hCAFE0000 | {22'd0, b_addr};
    task automatic step();
        @(posedge clk_n);
        #1;
    endtask
    task automatic test_reset();
        a_rst_n = 0; a_de_ready = 1; a_br_en = 0; a_br_addr = '0;
        b_rst_n = 0; b_de_ready = 0; b_br_en = 0; b_br_addr = '0;
        step(); step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_count); end
        checks++; if (a_addr !== 7'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", a_addr); end
        a_rst_n = 1; #1;
        checks++; if (a_rd_en !== 1'b1) begin errors++; $display("FAIL first_issue got %b exp 1", a_rd_en); end
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL cycle1_valid got %b exp 0", a_valid); end
        step();
        checks++;
        if ({a_valid, a_pc, a_inst} !== {1'b1, 7'h00, 16'h0100}) begin
            errors++; $display("FAIL cycle2_head got v=%b pc=%h inst=%h exp v=1 pc=00 inst=0100", a_valid, a_pc, a_inst);
        end
    endtask
    task automatic test_stream();
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({a_valid, a_pc, a_inst, a_next} !== {1'b1, 7'(k), 16'(256 + k), 7'(k + 1)}) begin
                errors++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h nxt=%h", k, a_valid, a_pc, a_inst, a_next);
            end
            checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL stream_count_%0d got %0d exp 1", k, a_count); end
        end
    endtask
    task automatic test_backpressure();
        int exp = 6;
        a_de_ready = 0;
        for (int i = 0; i < 10; i++) step();
        #1;
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", a_count); end
        checks++; if (a_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en got %b exp 0", a_rd_en); end
        a_de_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({a_valid, a_pc, a_inst} !== {1'b1, 7'(exp), 16'(256 + exp)}) begin
                errors++; $display("FAIL drain_%0d got v=%b pc=%h exp pc=%h", i, a_valid, a_pc, 7'(exp));
            end
            exp++;
            step();
        end
    endtask
    task automatic test_branch_full();
        a_de_ready = 0;
        step(); step(); step();
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL br_full_count got %0d exp 2", a_count); end
        a_br_en = 1; a_br_addr = 7'h40; #1;
        checks++; if (a_rd_en !== 1'b0) begin errors++; $display("FAIL br_no_issue got %b exp 0", a_rd_en); end
        step();
        a_br_en = 0; a_de_ready = 1; #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL br_flush_t1 got %b exp 0", a_valid); end
        checks++; if (a_addr !== 7'h40 || a_rd_en !== 1'b1) begin errors++; $display("FAIL br_issue got en=%b addr=%h exp 1 40", a_rd_en, a_addr); end
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL br_flush_t2 got %b exp 0", a_valid); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({a_valid, a_pc, a_inst} !== {1'b1, 7'(8'h40 + k), 16'(16'h0140 + k)}) begin
                errors++; $display("FAIL br_target_%0d got v=%b pc=%h inst=%h", k, a_valid, a_pc, a_inst);
            end
        end
    endtask
    task automatic test_wrap();
        a_br_en = 1; a_br_addr = 7'h7F;
        step();
        a_br_en = 0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush got %b exp 0", a_valid); end
        step(); step();
        checks++;
        if ({a_valid, a_pc, a_inst, a_next} !== {1'b1, 7'h7F, 16'h017F, 7'h00}) begin
            errors++; $display("FAIL wrap_top got v=%b pc=%h inst=%h nxt=%h", a_valid, a_pc, a_inst, a_next);
        end
        step();
        checks++;
        if ({a_valid, a_pc, a_inst, a_next} !== {1'b1, 7'h00, 16'h0100, 7'h01}) begin
            errors++; $display("FAIL wrap_zero got v=%b pc=%h inst=%h nxt=%h", a_valid, a_pc, a_inst, a_next);
        end
    endtask
    task automatic test_back_to_back();
        a_br_en = 1; a_br_addr = 7'h10;
        step();
        a_br_addr = 7'h20;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_t1 got %b exp 0", a_valid); end
        step();
        a_br_en = 0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_t2 got %b exp 0", a_valid); end
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_t3 got %b exp 0", a_valid); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({a_valid, a_pc, a_inst} !== {1'b1, 7'(8'h20 + k), 16'(16'h0120 + k)}) begin
                errors++; $display("FAIL b2b_stream_%0d got v=%b pc=%h inst=%h", k, a_valid, a_pc, a_inst);
            end
        end
    endtask
    task automatic test_reset_mid();
        a_de_ready = 0;
        step();
        checks++; if (a_count !== 2'd2) begin errors++; $display("FAIL rstmid_count got %0d exp 2", a_count); end
        a_de_ready = 1; a_rst_n = 0;
        step();
        checks++;
        if ({a_valid, a_count, a_addr} !== {1'b0, 2'd0, 7'h00}) begin
            errors++; $display("FAIL rstmid_clear got v=%b cnt=%0d addr=%h", a_valid, a_count, a_addr);
        end
        a_rst_n = 1;
        step();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rstmid_spurious got %b exp 0", a_valid); end
        step();
        checks++;
        if ({a_valid, a_pc, a_inst} !== {1'b1, 7'h00, 16'h0100}) begin
            errors++; $display("FAIL rstmid_restart got v=%b pc=%h inst=%h", a_valid, a_pc, a_inst);
        end
    endtask
    task automatic test_wide();
        int exp = 0;
        b_rst_n = 1;
        step(); step(); step();
        checks++;
        if ({b_valid, b_count, b_pc, b_inst} !== {1'b1, 3'd2, 10'h3FE, 32'hCAFE03FE}) begin
            errors++; $display("FAIL wide_fill got v=%b cnt=%0d pc=%h inst=%h", b_valid, b_count, b_pc, b_inst);
        end
        b_rst_n = 0;
        step();
        checks++;
        if ({b_valid, b_count, b_addr} !== {1'b0, 3'd0, 10'h3FE}) begin
            errors++; $display("FAIL wide_reset got v=%b cnt=%0d addr=%h", b_valid, b_count, b_addr);
        end
        b_rst_n = 1; b_de_ready = 1;
        step();
        checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL wide_spurious got %b exp 0", b_valid); end
        step();
        checks++;
        if ({b_valid, b_pc, b_inst, b_next} !== {1'b1, 10'h3FE, 32'hCAFE03FE, 10'h3FF}) begin
            errors++; $display("FAIL wide_first got v=%b pc=%h nxt=%h", b_valid, b_pc, b_next);
        end
        step();
        checks++;
        if ({b_valid, b_pc, b_next} !== {1'b1, 10'h3FF, 10'h000}) begin
            errors++; $display("FAIL wide_top got v=%b pc=%h nxt=%h", b_valid, b_pc, b_next);
        end
        step();
        checks++;
        if ({b_valid, b_pc, b_inst} !== {1'b1, 10'h000, 32'hCAFE0000}) begin
            errors++; $display("FAIL wide_zero got v=%b pc=%h inst=%h", b_valid, b_pc, b_inst);
        end
        b_de_ready = 0;
        for (int i = 0; i < 10; i++) step();
        #1;
        checks++; if (b_count !== 3'd4) begin errors++; $display("FAIL wide_sat_count got %0d exp 4", b_count); end
        checks++; if (b_rd_en !== 1'b0) begin errors++; $display("FAIL wide_sat_rd_en got %b exp 0", b_rd_en); end
        b_de_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({b_valid, b_pc, b_inst} !== {1'b1, 10'(exp), 32'hCAFE0000 | 32'(exp)}) begin
                errors++; $display("FAIL wide_drain_%0d got v=%b pc=%h exp pc=%h", i, b_valid, b_pc, 10'(exp));
            end
            exp++;
            step();
        end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
